// File: rtl/mlp_pkg.sv
// Shared definitions for the binary MLP layer: loader FSM states and
// parameter sizing helpers used by the loader, layer and neuron.
package mlp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WEIGHTS = 2'd1,
      THRESH  = 2'd2,
      COMMIT  = 2'd3
   } loader_state_t;

   function automatic int bytes_for_bits(input int n);
      return (n + 7) / 8;
   endfunction

   function automatic int thr_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mlp_param_loader_if.sv
// Byte stream carrying layer parameters into the loader (valid/ready).
interface mlp_param_loader_if;

   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   modport master (output in_data, output in_valid, input  in_ready);
   modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/mlp_param_loader.sv
// Assembles a neuron-by-neuron byte stream into shadow weight/threshold
// registers and commits the whole set to the layer in a single cycle.
module mlp_param_loader
   import mlp_pkg::*;
#(
   parameter int INPUT_SIZE      = 784,
   parameter int NUM_NEURONS     = 10,
   parameter int THRESHOLD_WIDTH = thr_width(INPUT_SIZE)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_start,
   input  logic                                   i_abort,
   mlp_param_loader_if.slave                      s_in,
   output logic [NUM_NEURONS*INPUT_SIZE-1:0]      o_weights,
   output logic [NUM_NEURONS*THRESHOLD_WIDTH-1:0] o_thresholds,
   output logic                                   o_params_valid,
   output logic                                   o_load_done,
   output logic                                   o_busy,
   output logic                                   o_thr_err
);

   localparam int WB     = bytes_for_bits(INPUT_SIZE);
   localparam int TB     = bytes_for_bits(THRESHOLD_WIDTH);
   localparam int BCW    = cnt_width(WB);
   localparam int TCW    = cnt_width(TB);
   localparam int NCW    = cnt_width(NUM_NEURONS);
   localparam int TBITS  = TB * 8;
   localparam int WBITS  = NUM_NEURONS * INPUT_SIZE;
   localparam int TWBITS = NUM_NEURONS * THRESHOLD_WIDTH;
   localparam int WIX    = cnt_width(WBITS);
   localparam int TIX    = cnt_width(TWBITS);

   localparam logic [BCW-1:0]   B_LAST  = BCW'(WB - 1);
   localparam logic [TCW-1:0]   T_LAST  = TCW'(TB - 1);
   localparam logic [NCW-1:0]   N_LAST  = NCW'(NUM_NEURONS - 1);
   localparam logic [TBITS-1:0] THR_MAX = TBITS'(INPUT_SIZE);

   loader_state_t     r_state, w_state_nxt;
   logic [BCW-1:0]    r_bcnt, w_bcnt_nxt;
   logic [TCW-1:0]    r_tcnt, w_tcnt_nxt;
   logic [NCW-1:0]    r_ncnt, w_ncnt_nxt;
   logic              w_ready, w_xfer, w_start, w_commit, w_thr_bad;
   logic [TBITS-1:0]  r_thr_acc, w_thr_full;
   logic [WBITS-1:0]  r_shadow_w, w_shadow_w_nxt, r_weights;
   logic [TWBITS-1:0] r_shadow_t, w_shadow_t_nxt, r_thresholds;
   logic [WIX-1:0]    w_widx;
   logic [TIX-1:0]    w_tbase;
   logic              r_params_valid, r_load_done, r_thr_err;

   // Ready depends only on registered state; abort outranks a same-cycle byte.
   assign w_ready       = (r_state == WEIGHTS) || (r_state == THRESH);
   assign w_xfer        = s_in.in_valid & w_ready & ~i_abort;
   assign s_in.in_ready = w_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_bcnt  <= '0;
         r_tcnt  <= '0;
         r_ncnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_ncnt  <= w_ncnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bcnt_nxt  = r_bcnt;
      w_tcnt_nxt  = r_tcnt;
      w_ncnt_nxt  = r_ncnt;
      w_start     = 1'b0;
      w_commit    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start && !i_abort) begin
               w_state_nxt = WEIGHTS;
               w_bcnt_nxt  = '0;
               w_tcnt_nxt  = '0;
               w_ncnt_nxt  = '0;
               w_start     = 1'b1;
            end
         end
         WEIGHTS: begin
            if (i_abort) begin
               w_state_nxt = IDLE;
            end else if (w_xfer) begin
               if (r_bcnt == B_LAST) begin
                  w_bcnt_nxt  = '0;
                  w_state_nxt = THRESH;
               end else begin
                  w_bcnt_nxt = r_bcnt + 1'b1;
               end
            end
         end
         THRESH: begin
            if (i_abort) begin
               w_state_nxt = IDLE;
            end else if (w_xfer) begin
               if (r_tcnt == T_LAST) begin
                  w_tcnt_nxt = '0;
                  if (r_ncnt == N_LAST) begin
                     w_ncnt_nxt  = '0;
                     w_state_nxt = COMMIT;
                  end else begin
                     w_ncnt_nxt  = r_ncnt + 1'b1;
                     w_state_nxt = WEIGHTS;
                  end
               end else begin
                  w_tcnt_nxt = r_tcnt + 1'b1;
               end
            end
         end
         COMMIT: begin
            w_state_nxt = IDLE;
            w_commit    = ~i_abort;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shadow update; bytes of a threshold arrive in order, so OR-ing works.
   always_comb begin
      w_shadow_w_nxt = r_shadow_w;
      w_shadow_t_nxt = r_shadow_t;
      w_widx         = '0;
      w_tbase        = TIX'(int'(r_ncnt) * THRESHOLD_WIDTH);
      w_thr_bad      = 1'b0;
      w_thr_full     = ((r_tcnt == '0) ? '0 : r_thr_acc)
                       | (TBITS'(s_in.in_data) << (8 * int'(r_tcnt)));
      if (w_xfer && (r_state == WEIGHTS)) begin
         for (int j = 0; j < 8; j++) begin
            if (int'(r_bcnt) * 8 + j < INPUT_SIZE) begin
               w_widx = WIX'(int'(r_ncnt) * INPUT_SIZE + int'(r_bcnt) * 8 + j);
               w_shadow_w_nxt[w_widx] = s_in.in_data[j];
            end
         end
      end
      if (w_xfer && (r_state == THRESH) && (r_tcnt == T_LAST)) begin
         w_shadow_t_nxt[w_tbase +: THRESHOLD_WIDTH] = w_thr_full[THRESHOLD_WIDTH-1:0];
         w_thr_bad = ((w_thr_full >> THRESHOLD_WIDTH) != '0) || (w_thr_full > THR_MAX);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_thr_acc      <= '0;
         r_shadow_w     <= '0;
         r_shadow_t     <= '0;
         r_weights      <= '0;
         r_thresholds   <= '0;
         r_params_valid <= 1'b0;
         r_load_done    <= 1'b0;
         r_thr_err      <= 1'b0;
      end else begin
         r_shadow_w  <= w_shadow_w_nxt;
         r_shadow_t  <= w_shadow_t_nxt;
         r_load_done <= w_commit;
         if (w_xfer && (r_state == THRESH))
            r_thr_acc <= w_thr_full;
         if (w_start)
            r_thr_err <= 1'b0;
         else if (w_thr_bad)
            r_thr_err <= 1'b1;
         if (w_commit) begin
            r_weights      <= r_shadow_w;
            r_thresholds   <= r_shadow_t;
            r_params_valid <= 1'b1;
         end
      end
   end

   assign o_weights      = r_weights;
   assign o_thresholds   = r_thresholds;
   assign o_params_valid = r_params_valid;
   assign o_load_done    = r_load_done;
   assign o_busy         = (r_state != IDLE);
   assign o_thr_err      = r_thr_err;

endmodule

// File: tb/tb_mlp_param_loader.sv
// Self-checking bench for mlp_param_loader with a 12-input, 2-neuron layer.
`timescale 1ns/1ps
module tb_mlp_param_loader;

   localparam int IS = 12;
   localparam int NN = 2;
   localparam int TW = 4;
   localparam int NB = 6;
   typedef logic [7:0] bytes_t [NB];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [NN*IS-1:0] weights;
   logic [NN*TW-1:0] thresholds;
   logic pv, ld, busy, terr;

   int n_checks = 0;
   int n_fail   = 0;
   int ld_count = 0;

   logic [NN*IS-1:0] exp_w   = '0;
   logic [NN*TW-1:0] exp_t   = '0;
   logic             exp_pv  = 1'b0;
   logic             exp_err = 1'b0;

   mlp_param_loader_if u_if ();

   mlp_param_loader #(
      .INPUT_SIZE(IS), .NUM_NEURONS(NN), .THRESHOLD_WIDTH(TW)
   ) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .s_in(u_if),
      .o_weights(weights), .o_thresholds(thresholds), .o_params_valid(pv),
      .o_load_done(ld), .o_busy(busy), .o_thr_err(terr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ld === 1'b1) ld_count++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Reference: each neuron is 2 little-endian weight bytes + 1 threshold byte.
   task automatic model_commit(input bytes_t b);
      int wv, tv;
      exp_err = 1'b0;
      for (int n = 0; n < NN; n++) begin
         wv = (int'(b[3*n]) + 256 * int'(b[3*n+1])) % (1 << IS);
         tv = int'(b[3*n+2]);
         if (tv > IS || tv >= (1 << TW)) exp_err = 1'b1;
         exp_w[n*IS +: IS] = wv[IS-1:0];
         exp_t[n*TW +: TW] = tv[TW-1:0];
      end
      exp_pv = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, input int gap);
      int waitc;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      u_if.in_data  = v;
      u_if.in_valid = 1'b1;
      waitc = 0;
      while (u_if.in_ready !== 1'b1 && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      n_checks++;
      if (waitc >= 20) begin
         n_fail++;
         $display("FAIL send_byte_timeout: in_ready=%b required 1", u_if.in_ready);
      end else begin
         @(posedge clk);
      end
      #1 u_if.in_valid = 1'b0;
   endtask

   task automatic load(input bytes_t b, input int maxgap);
      do_start();
      for (int i = 0; i < NB; i++) send_byte(b[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({weights, thresholds, pv, ld, busy, terr, u_if.in_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: w=%h t=%h pv=%b ld=%b busy=%b err=%b rdy=%b required all 0",
                  weights, thresholds, pv, ld, busy, terr, u_if.in_ready);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || u_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b rdy=%b required 0 0", busy, u_if.in_ready);
      end
   endtask

   task automatic test_basic();
      bytes_t b;
      int ld0;
      b = '{8'hA5, 8'h0F, 8'h07, 8'h3C, 8'h05, 8'h0C};
      ld0 = ld_count;
      do_start();
      n_checks++;
      if (busy !== 1'b1 || u_if.in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_after_start: busy=%b rdy=%b required 1 1", busy, u_if.in_ready);
      end
      for (int i = 0; i < NB; i++) send_byte(b[i], 0);
      model_commit(b);
      @(negedge clk);
      n_checks++;
      if (ld !== 1'b0 || u_if.in_ready !== 1'b0 || busy !== 1'b1 || weights !== '0) begin
         n_fail++;
         $display("FAIL basic_commit_cycle: ld=%b rdy=%b busy=%b w=%h required 0 0 1 000000",
                  ld, u_if.in_ready, busy, weights);
      end
      @(negedge clk);
      n_checks++;
      if (ld !== 1'b1 || weights !== 24'h53CFA5 || thresholds !== 8'hC7 || pv !== 1'b1 || terr !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_result: ld=%b w=%h t=%h pv=%b err=%b required 1 53cfa5 c7 1 0",
                  ld, weights, thresholds, pv, terr);
      end
      n_checks++;
      if (weights !== exp_w || thresholds !== exp_t) begin
         n_fail++;
         $display("FAIL basic_model: w=%h t=%h required %h %h", weights, thresholds, exp_w, exp_t);
      end
      @(negedge clk);
      n_checks++;
      if (ld !== 1'b0 || busy !== 1'b0 || ld_count - ld0 !== 1) begin
         n_fail++;
         $display("FAIL basic_pulse: ld=%b busy=%b pulses=%0d required 0 0 1", ld, busy, ld_count - ld0);
      end
   endtask

   task automatic test_abort();
      bytes_t b;
      int ld0;
      ld0 = ld_count;
      do_start();
      for (int i = 0; i < 3; i++) send_byte(8'h5A ^ 8'(i), 0);
      @(negedge clk);
      abort = 1'b1; u_if.in_valid = 1'b1; u_if.in_data = 8'hEE;
      @(posedge clk); #1 abort = 1'b0; u_if.in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || u_if.in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b rdy=%b required 0 0", busy, u_if.in_ready);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (weights !== exp_w || thresholds !== exp_t || pv !== 1'b1 || ld_count !== ld0) begin
         n_fail++;
         $display("FAIL abort_kept: w=%h t=%h pv=%b pulses=%0d required %h %h 1 0",
                  weights, thresholds, pv, ld_count - ld0, exp_w, exp_t);
      end
      b = '{8'h11, 8'h02, 8'h03, 8'h44, 8'h05, 8'h06};
      load(b, 0);
      model_commit(b);
      repeat (3) @(negedge clk);
      n_checks++;
      if (weights !== exp_w || thresholds !== exp_t || ld_count - ld0 !== 1) begin
         n_fail++;
         $display("FAIL abort_reload: w=%h t=%h pulses=%0d required %h %h 1",
                  weights, thresholds, ld_count - ld0, exp_w, exp_t);
      end
   endtask

   task automatic test_idle_ctrl();
      @(negedge clk); start = 1'b1; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_start_abort: busy=%b required 0", busy);
      end
   endtask

   task automatic test_gaps();
      bytes_t b;
      int ld0;
      b = '{8'hA5, 8'h0F, 8'h07, 8'h3C, 8'h05, 8'h0C};
      ld0 = ld_count;
      load(b, 4);
      model_commit(b);
      u_if.in_valid = 1'b1; u_if.in_data = 8'hFF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (u_if.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_ready_low: cycle %0d rdy=%b required 0", c, u_if.in_ready);
         end
      end
      u_if.in_valid = 1'b0;
      n_checks++;
      if (weights !== 24'h53CFA5 || thresholds !== 8'hC7 || terr !== 1'b0 || ld_count - ld0 !== 1) begin
         n_fail++;
         $display("FAIL gaps_result: w=%h t=%h err=%b pulses=%0d required 53cfa5 c7 0 1",
                  weights, thresholds, terr, ld_count - ld0);
      end
   endtask

   task automatic test_thr_err();
      bytes_t b;
      int ld0;
      b = '{8'hA5, 8'h0F, 8'h0D, 8'h3C, 8'h05, 8'h1C};
      ld0 = ld_count;
      load(b, 0);
      model_commit(b);
      repeat (3) @(negedge clk);
      n_checks++;
      if (terr !== 1'b1 || thresholds !== 8'hCD || weights !== 24'h53CFA5 || ld_count - ld0 !== 1) begin
         n_fail++;
         $display("FAIL thr_err_load: err=%b t=%h w=%h pulses=%0d required 1 cd 53cfa5 1",
                  terr, thresholds, weights, ld_count - ld0);
      end
      do_start();
      n_checks++;
      if (terr !== 1'b0) begin
         n_fail++;
         $display("FAIL thr_err_clear_on_start: err=%b required 0", terr);
      end
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
   endtask

   task automatic test_start_ignored();
      bytes_t b;
      b = '{8'hC3, 8'h0A, 8'h09, 8'h7E, 8'h01, 8'h02};
      do_start();
      send_byte(b[0], 0);
      send_byte(b[1], 0);
      do_start();
      for (int i = 2; i < NB; i++) send_byte(b[i], 0);
      model_commit(b);
      repeat (3) @(negedge clk);
      n_checks++;
      if (weights !== exp_w || thresholds !== exp_t || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_ignored: w=%h t=%h busy=%b required %h %h 0",
                  weights, thresholds, busy, exp_w, exp_t);
      end
   endtask

   task automatic test_random();
      bytes_t b;
      int waitc;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NB; i++) begin
            if (i % 3 == 2)
               b[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, IS));
            else
               b[i] = 8'($urandom_range(0, 255));
         end
         load(b, 3);
         model_commit(b);
         waitc = 0;
         while (ld !== 1'b1 && waitc < 6) begin
            @(negedge clk);
            waitc++;
         end
         n_checks++;
         if (waitc !== 2) begin
            n_fail++;
            $display("FAIL random_latency[%0d]: negedges=%0d required 2", r, waitc);
         end
         n_checks++;
         if (weights !== exp_w || thresholds !== exp_t || terr !== exp_err || pv !== exp_pv) begin
            n_fail++;
            $display("FAIL random_result[%0d]: w=%h t=%h err=%b pv=%b required %h %h %b %b",
                     r, weights, thresholds, terr, pv, exp_w, exp_t, exp_err, exp_pv);
         end
      end
   endtask

   task automatic test_reset_midload();
      bytes_t b;
      do_start();
      for (int i = 0; i < 4; i++) send_byte(8'h3C + 8'(i), 0);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({weights, thresholds, pv, ld, busy, terr, u_if.in_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_midload: w=%h t=%h pv=%b ld=%b busy=%b err=%b rdy=%b required all 0",
                  weights, thresholds, pv, ld, busy, terr, u_if.in_ready);
      end
      @(negedge clk); rst = 1'b0;
      exp_w = '0; exp_t = '0; exp_pv = 1'b0; exp_err = 1'b0;
      b = '{8'h81, 8'h07, 8'h0B, 8'hFF, 8'hFF, 8'h00};
      load(b, 1);
      model_commit(b);
      repeat (3) @(negedge clk);
      n_checks++;
      if (weights !== exp_w || thresholds !== exp_t || pv !== 1'b1 || terr !== exp_err) begin
         n_fail++;
         $display("FAIL reset_reload: w=%h t=%h pv=%b err=%b required %h %h 1 %b",
                  weights, thresholds, pv, terr, exp_w, exp_t, exp_err);
      end
   endtask

   initial begin
      u_if.in_data  = 8'h00;
      u_if.in_valid = 1'b0;
      test_reset();
      test_basic();
      test_abort();
      test_idle_ctrl();
      test_gaps();
      test_thr_err();
      test_start_ignored();
      test_random();
      test_reset_midload();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
